// File: rtl/pc_unit_pkg.sv
// Shared types and default addresses for the program-counter stage.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    PC_SEQ   = 2'd0,
    PC_DELAY = 2'd1,
    PC_HALT  = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] PC_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/pc_unit_if.sv
// Control/datapath bundle between the decoder side and the next-PC stage.
interface pc_unit_if;

  logic        stall;
  logic        branch;
  logic        cond_met;
  logic        jump1;
  logic        jump2;
  logic [15:0] imdt;
  logic [25:0] instr_index;
  logic [31:0] reg_a;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        in_delay;
  logic        active;

  modport master (
    output stall, branch, cond_met, jump1, jump2, imdt, instr_index, reg_a,
    input  pc, link_addr, in_delay, active
  );

  modport slave (
    input  stall, branch, cond_met, jump1, jump2, imdt, instr_index, reg_a,
    output pc, link_addr, in_delay, active
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational control-transfer target selection from the current pc.
module pc_target_calc (
  input  logic [31:0] pc,
  input  logic [15:0] imdt,
  input  logic [25:0] instr_index,
  input  logic [31:0] reg_a,
  input  logic        branch,
  input  logic        cond_met,
  input  logic        jump1,
  input  logic        jump2,
  output logic        taken,
  output logic [31:0] target,
  output logic [31:0] pc_plus4
);

  logic signed [31:0] br_off;
  logic        [31:0] br_tgt;
  logic        [31:0] j_tgt;

  // Word offset to byte offset, sign-extended to the full address width.
  function automatic logic signed [31:0] word_to_byte_off(input logic [15:0] off);
    return $signed({{14{off[15]}}, off, 2'b00});
  endfunction

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = word_to_byte_off(imdt);
  assign br_tgt   = pc_plus4 + $unsigned(br_off);
  assign j_tgt    = {pc_plus4[31:28], instr_index, 2'b00};

  always_comb begin
    taken  = 1'b1;
    target = reg_a;
    if (jump2) begin
      target = reg_a;
    end else if (jump1) begin
      target = j_tgt;
    end else if (branch && cond_met) begin
      target = br_tgt;
    end else begin
      taken  = 1'b0;
      target = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Next-PC stage: sequential fetch, one-instruction branch delay slot, link
// address and halt on a control transfer to the halt address.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = PC_HALT_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  pc_unit_if.slave   bus
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        in_delay_q, in_delay_d;
  logic        active_q, active_d;

  logic        taken;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  pc_target_calc u_target (
    .pc          (pc_q),
    .imdt        (bus.imdt),
    .instr_index (bus.instr_index),
    .reg_a       (bus.reg_a),
    .branch      (bus.branch),
    .cond_met    (bus.cond_met),
    .jump1       (bus.jump1),
    .jump2       (bus.jump2),
    .taken       (taken),
    .target      (target),
    .pc_plus4    (pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PC_SEQ;
      pc_q       <= RESET_VECTOR;
      pending_q  <= '0;
      in_delay_q <= 1'b0;
      active_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      in_delay_q <= in_delay_d;
      active_q   <= active_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_SEQ:   if (!bus.stall && taken) state_d = PC_DELAY;
      PC_DELAY: if (!bus.stall) state_d = (pending_q == HALT_ADDR) ? PC_HALT : PC_SEQ;
      PC_HALT:  state_d = PC_HALT;
      default:  state_d = PC_SEQ;
    endcase
  end

  // Transfer inputs seen while in the delay slot are ignored: pending wins.
  always_comb begin
    pc_d       = pc_q;
    pending_d  = pending_q;
    in_delay_d = in_delay_q;
    active_d   = active_q;
    case (state_q)
      PC_SEQ: begin
        if (!bus.stall) begin
          pc_d = pc_plus4;
          if (taken) begin
            pending_d  = target;
            in_delay_d = 1'b1;
          end
        end
      end
      PC_DELAY: begin
        if (!bus.stall) begin
          pc_d       = pending_q;
          in_delay_d = 1'b0;
          if (pending_q == HALT_ADDR) active_d = 1'b0;
        end
      end
      PC_HALT: begin
        active_d = 1'b0;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  assign bus.pc        = pc_q;
  assign bus.link_addr = pc_q + 32'd8;
  assign bus.in_delay  = in_delay_q;
  assign bus.active    = active_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table plus randomized run against a reference model.
module tb_pc_unit;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  pc_unit_if bus ();

  pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic        cm;
    logic        j1;
    logic        j2;
    logic [15:0] imdt;
    logic [25:0] idx;
    logic [31:0] rega;
    logic [31:0] exp_pc;
    logic        exp_dly;
    logic        exp_act;
  } vec_t;

  vec_t vecs[$];

  // Reference model: pc, a queue of redirects owed after the delay slot, halt flag.
  logic [31:0] m_pc;
  logic [31:0] m_redirect[$];
  logic        m_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic br, input logic cm,
                       input logic j1, input logic j2, input logic [15:0] imdt,
                       input logic [25:0] idx, input logic [31:0] rega);
    reset           = rst;
    bus.stall       = stall;
    bus.branch      = br;
    bus.cond_met    = cm;
    bus.jump1       = j1;
    bus.jump2       = j2;
    bus.imdt        = imdt;
    bus.instr_index = idx;
    bus.reg_a       = rega;
  endtask

  task automatic add(input logic rst, input logic stall, input logic br, input logic cm,
                     input logic j1, input logic j2, input logic [15:0] imdt,
                     input logic [25:0] idx, input logic [31:0] rega,
                     input logic [31:0] epc, input logic edly, input logic eact);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.cm = cm; v.j1 = j1; v.j2 = j2;
    v.imdt = imdt; v.idx = idx; v.rega = rega;
    v.exp_pc = epc; v.exp_dly = edly; v.exp_act = eact;
    vecs.push_back(v);
  endtask

  task automatic model_step(input logic rst, input logic stall, input logic br, input logic cm,
                            input logic j1, input logic j2, input logic [15:0] imdt,
                            input logic [25:0] idx, input logic [31:0] rega);
    logic [31:0] seq_next;
    logic [31:0] tgt;
    logic        tk;
    if (rst) begin
      m_pc = 32'hBFC0_0000;
      m_redirect.delete();
      m_halt = 1'b0;
      return;
    end
    if (m_halt || stall) return;
    seq_next = m_pc + 32'd4;
    tk  = 1'b1;
    tgt = 32'd0;
    if (j2)           tgt = rega;
    else if (j1)      tgt = {seq_next[31:28], idx, 2'b00};
    else if (br && cm) tgt = seq_next + 32'(signed'(imdt) * 4);
    else              tk = 1'b0;
    if (m_redirect.size() > 0) begin
      m_pc = m_redirect.pop_front();
      if (m_pc == 32'd0) m_halt = 1'b1;
    end else begin
      m_pc = seq_next;
      if (tk) m_redirect.push_back(tgt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);

    // 1: reset and sequential fetch
    add(1, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0004, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0008, 0, 1);
    // 2: branch forward, backward, not taken
    add(1, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1);
    add(0, 0, 1, 1, 0, 0, 16'h0004, 26'h0, 32'h0, 32'hBFC0_0004, 1, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0014, 0, 1);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1);
    add(0, 0, 1, 1, 0, 0, 16'hFFFF, 26'h0, 32'h0, 32'hBFC0_0004, 1, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1);
    add(0, 0, 1, 0, 0, 0, 16'h0004, 26'h0, 32'h0, 32'hBFC0_0004, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0008, 0, 1);
    // 3: J from BFC00010, then J+JR together (JR wins)
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_000C, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0010, 0, 1);
    add(0, 0, 0, 0, 1, 0, 16'h0000, 26'h40, 32'h0, 32'hBFC0_0014, 1, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hB000_0100, 0, 1);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0004, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0008, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_000C, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0010, 0, 1);
    add(0, 0, 1, 1, 1, 1, 16'h0004, 26'h40, 32'hBFC0_0200, 32'hBFC0_0014, 1, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0200, 0, 1);
    // 4: JR to zero halts after the delay slot; inputs then ignored
    add(0, 0, 0, 0, 0, 1, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0204, 1, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_0000, 0, 0);
    add(0, 0, 1, 1, 1, 0, 16'h0004, 26'h40, 32'h0, 32'h0000_0000, 0, 0);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 26'h0, 32'h1234_0000, 32'h0000_0000, 0, 0);
    // 5: stall in delay slot, then pending loads
    add(1, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1);
    add(0, 0, 0, 0, 1, 0, 16'h0000, 26'h40, 32'h0, 32'hBFC0_0004, 1, 1);
    add(0, 1, 1, 1, 0, 0, 16'h0010, 26'h0, 32'h0, 32'hBFC0_0004, 1, 1);
    add(0, 1, 0, 0, 0, 1, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0004, 1, 1);
    add(0, 1, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0004, 1, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hB000_0100, 0, 1);
    // transfer in delay slot ignored, pending wins, no halt
    add(1, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1);
    add(0, 0, 1, 1, 0, 0, 16'h0004, 26'h0, 32'h0, 32'hBFC0_0004, 1, 1);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0014, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0018, 0, 1);
    // 6: reset in delay slot discards pending; reset with stall while halted
    add(0, 0, 0, 0, 1, 0, 16'h0000, 26'h40, 32'h0, 32'hBFC0_001C, 1, 1);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0004, 0, 1);
    add(0, 0, 0, 0, 0, 1, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0008, 1, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'h0000_0000, 0, 0);
    add(1, 1, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0004, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].cm, vecs[i].j1, vecs[i].j2,
            vecs[i].imdt, vecs[i].idx, vecs[i].rega);
      tick();
      check($sformatf("vec%0d pc", i), bus.pc, vecs[i].exp_pc);
      check($sformatf("vec%0d link_addr", i), bus.link_addr, vecs[i].exp_pc + 32'd8);
      check($sformatf("vec%0d in_delay", i), 32'(bus.in_delay), 32'(vecs[i].exp_dly));
      check($sformatf("vec%0d active", i), 32'(bus.active), 32'(vecs[i].exp_act));
    end

    // Halted CPU holds through random non-reset activity.
    drive(0, 0, 0, 0, 0, 1, 16'h0, 26'h0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom), 26'($urandom), $urandom);
      tick();
      check($sformatf("halt_hold%0d pc", k), bus.pc, 32'h0);
      check($sformatf("halt_hold%0d link", k), bus.link_addr, 32'h8);
      check($sformatf("halt_hold%0d active", k), 32'(bus.active), 32'd0);
    end

    // Randomized run against the reference model.
    drive(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    model_step(1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    tick();
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_stall, r_br, r_cm, r_j1, r_j2;
      logic [15:0] r_imdt;
      logic [25:0] r_idx;
      logic [31:0] r_rega;
      r_rst   = ($urandom_range(0, 47) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_br    = ($urandom_range(0, 2) == 0);
      r_cm    = 1'($urandom);
      r_j1    = ($urandom_range(0, 5) == 0);
      r_j2    = ($urandom_range(0, 5) == 0);
      r_imdt  = 16'($urandom);
      r_idx   = 26'($urandom);
      r_rega  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      drive(r_rst, r_stall, r_br, r_cm, r_j1, r_j2, r_imdt, r_idx, r_rega);
      model_step(r_rst, r_stall, r_br, r_cm, r_j1, r_j2, r_imdt, r_idx, r_rega);
      tick();
      check($sformatf("rnd%0d pc", n), bus.pc, m_pc);
      check($sformatf("rnd%0d link_addr", n), bus.link_addr, m_pc + 32'd8);
      check($sformatf("rnd%0d in_delay", n), 32'(bus.in_delay), 32'(m_redirect.size() > 0));
      check($sformatf("rnd%0d active", n), 32'(bus.active), 32'(!m_halt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
